imem_stream_loader: RTL
=======================

Name: imem_stream_loader

Overview:
Synthesizable program loader; the hardware writer for instruction memory, replacing the simulation-only hex preload.
- Receives a framed little-endian byte stream (host/UART side) over a valid/ready handshake.
- Assembles 32-bit words and writes them sequentially into the imem write port from word 0.
- Holds the CPU in reset until a frame completes with a good checksum.

Parameters:
ADDR_W, 10, imem word-address width; capacity 2^ADDR_W words
LEN_W, 16, width of frame length field (word count), fixed at 16 by framing

Ports:
sys_clk  in  1  system clock, all state on rising edge
sys_rst_n  in  1  asynchronous active-low reset
rx_data  in  8  incoming stream byte
rx_valid  in  1  rx_data valid this cycle
rx_ready  out  1  loader accepts byte; transfer when rx_valid&&rx_ready
load_start  in  1  single-cycle pulse; re-arms loader from S_DONE or S_ERR
imem_we  out  1  imem write strobe, one cycle per word
imem_addr  out  ADDR_W  imem word address
imem_wdata  out  32  imem write data
cpu_rst_n  out  1  active-low CPU reset; high only in S_DONE
load_done  out  1  frame loaded and checksum matched
load_err  out  1  frame rejected

Behaviour:
- Frame format: LEN_LO, LEN_HI (word count N), then 4*N data bytes (LSB first per word), then CSUM.
  - CSUM is the XOR of all data bytes; length bytes are excluded.
- States: S_LEN0 -> S_LEN1 -> S_DATA -> S_CSUM -> S_DONE | S_ERR.
- Reset (async, any state, including mid-frame):
  - State = S_LEN0; byte/word counters, checksum accumulator and word shift register = 0.
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0.
  - imem contents are not touched.
- rx_ready is 1 in S_LEN0, S_LEN1, S_DATA and S_CSUM; 0 in S_DONE and S_ERR.
- Bytes are consumed only on handshake cycles; rx_valid gaps of any length are legal and leave state unchanged.
- S_LEN0: latch the low length byte, go to S_LEN1.
- S_LEN1: latch the high byte into N.
  - N > 2^ADDR_W: go to S_ERR.
  - N == 0: go to S_CSUM.
  - Otherwise: go to S_DATA.
- S_DATA:
  - Shift each byte into bits [8*k+7:8*k], where k is the byte index 0..3 within the word.
  - XOR each byte into the accumulator.
  - On the 4th byte: next cycle imem_we=1, imem_wdata=assembled word, imem_addr=word index.
  - The word index then increments; imem_we is low otherwise.
  - Writes are pipelined one cycle behind acceptance, with no stall; back-to-back bytes every cycle are sustained.
  - After word N-1 is accepted, go to S_CSUM.
- S_CSUM: compare the byte with the accumulator.
  - Match: go to S_DONE.
  - Mismatch: go to S_ERR.
  - The final imem write, if pending, still issues that same cycle.
- S_DONE: load_done=1, cpu_rst_n=1.
- S_ERR: load_err=1, cpu_rst_n=0.
  - Partially written imem words remain and are not scrubbed.
- load_start in S_DONE/S_ERR:
  - Clears flags and counters, drops cpu_rst_n, returns to S_LEN0.
  - load_start in any other state is ignored.
- Word-index wrap: cannot occur; the length check bounds the index to N-1 ≤ 2^ADDR_W-1.
- All outputs are registered; there is no combinational path from rx_* to imem_* or to the status outputs.

Decomposition:
- Shared package loader_pkg:
  - State encodings S_LEN0..S_ERR.
  - Frame constants: LEN field bytes = 2, bytes per word = 4.
  - Checksum init value 8'h00.
- One natural sub-module, loader_word_asm:
  - Byte-to-word shift register, byte index counter and XOR accumulator.
  - Outputs word_valid/word.
- The top holds the FSM, word index, imem port registers and status.

Test Plan:
- Nominal load: 02 00 13 05 00 00 73 00 10 00 75.
  - imem[0]=0x00000513, imem[1]=0x00100073, exactly 2 imem_we pulses.
  - load_done=1, cpu_rst_n=1.
- Bad checksum: same frame with CSUM=0x74.
  - Both words still written; load_err=1, load_done=0, cpu_rst_n stays 0.
- Zero length: 00 00 00.
  - No imem_we; load_done=1.
  - 00 00 01 (after reset) gives load_err=1.
- Oversize, ADDR_W=10: 01 04 (N=1025).
  - load_err=1 right after LEN_HI; rx_ready=0; no writes.
- Throttled stream:
  - Nominal frame with random 0-5 cycle rx_valid gaps: identical imem contents and write order.
  - rx_valid held high every cycle: no dropped bytes.
- Reset and re-arm:
  - Assert sys_rst_n=0 after 5 data bytes: outputs go to reset values asynchronously.
  - Reload the nominal frame: success.
  - Then pulse load_start and send 01 00 EF BE AD DE 22: imem[0]=0xDEADBEEF, load_done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and framing constants for the imem stream loader
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } loader_state_t;

  localparam int          LEN_BYTES      = 2;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [7:0]  CSUM_INIT      = 8'h00;

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - little-endian byte-to-word assembler with running XOR checksum
module loader_word_asm
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  idx;
  logic [23:0] shreg;
  logic [7:0]  acc;

  // The 4th byte completes the word combinationally; the top registers it into the imem port
  assign word_valid = byte_en && (idx == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, shreg};
  assign csum       = acc;

  // Shift accepted bytes into their lane and fold them into the checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      shreg <= '0;
      acc   <= CSUM_INIT;
    end else if (clr) begin
      idx   <= '0;
      shreg <= '0;
      acc   <= CSUM_INIT;
    end else if (byte_en) begin
      acc <= acc ^ byte_data;
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    shreg[7:0]   <= byte_data;
        2'd1:    shreg[15:8]  <= byte_data;
        2'd2:    shreg[23:16] <= byte_data;
        default: shreg        <= '0;
      endcase
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - framed byte-stream program loader driving the imem write port
module imem_stream_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  loader_state_t    state;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;

  logic             hs;
  logic             rearm;
  logic [LEN_W-1:0] len_next;
  logic             asm_valid;
  logic [31:0]      asm_word;
  logic [7:0]       asm_csum;

  assign hs       = rx_valid && rx_ready;
  assign rearm    = load_start && ((state == S_DONE) || (state == S_ERR));
  assign len_next = {rx_data, len_lo};

  loader_word_asm u_word_asm (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .clr        (rearm),
    .byte_en    (hs && (state == S_DATA)),
    .byte_data  (rx_data),
    .word_valid (asm_valid),
    .word       (asm_word),
    .csum       (asm_csum)
  );

  // Frame parser: length, data words with one-cycle-delayed imem write, checksum, status
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_LEN0;
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN0: begin
          if (hs) begin
            len_lo <= rx_data;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (hs) begin
            len      <= len_next;
            word_cnt <= '0;
            if (32'(len_next) > MAX_WORDS) begin
              state    <= S_ERR;
              load_err <= 1'b1;
              rx_ready <= 1'b0;
            end else if (len_next == '0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (asm_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= asm_word;
            word_cnt   <= word_cnt + LEN_W'(1);
            if (word_cnt == len - LEN_W'(1)) begin
              state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (hs) begin
            rx_ready <= 1'b0;
            if (rx_data == asm_csum) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (load_start) begin
            state     <= S_LEN0;
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            rx_ready  <= 1'b1;
            cpu_rst_n <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end
        end
        default: begin
          state    <= S_LEN0;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
